// File: rtl/dsp_sched_pkg.sv
// Shared types and constants for the dsp_sched scheduler.
// Covers the result buffer entry, the pipeline tag and the datapath depth.
package dsp_sched_pkg;

  localparam int DSP_LATENCY   = 3;
  localparam int RES_W_DEFAULT = 16;

  typedef struct packed {
    logic [RES_W_DEFAULT-1:0] p;
    logic                     match;
    logic                     id;
  } res_t;

  typedef struct packed {
    logic valid;
    logic id;
  } tag_t;

endpackage

// File: rtl/dsp_res_fifo.sv
// Non-fall-through result buffer. Push and pop may occur in the same cycle.
// Occupancy is exported so the issuing side can reserve a slot per request.
module dsp_res_fifo
  import dsp_sched_pkg::*;
#(
  parameter int  DEPTH  = 4,
  parameter type item_t = res_t
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  item_t                      din,
  input  logic                       pop,
  output item_t                      dout,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  item_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          full;
  logic          do_pop;

  assign full   = (cnt == CW'(DEPTH));
  assign empty  = (cnt == '0);
  assign do_pop = pop && !empty;
  assign dout   = mem[rd_ptr];
  assign count  = cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push)
        wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + AW'(1);
      if (do_pop)
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + AW'(1);
      cnt <= cnt + CW'(push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= din;
  end

  // The upstream credit check must make this unreachable.
  always_ff @(posedge clk) begin
    if (!rst)
      assert (!(push && full && !do_pop));
  end

endmodule

// File: rtl/dsp_sched.sv
// Two-requester round-robin front end feeding a 3-stage (a+d)*b pipeline.
// Results are buffered in dsp_res_fifo; issue is gated by a credit count.
module dsp_sched
  import dsp_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s0_valid,
  output logic                  s0_ready,
  input  logic [DATA_WIDTH-1:0] s0_a,
  input  logic [DATA_WIDTH-1:0] s0_b,
  input  logic [DATA_WIDTH-1:0] s0_c,
  input  logic [DATA_WIDTH-1:0] s0_d,
  input  logic                  s1_valid,
  output logic                  s1_ready,
  input  logic [DATA_WIDTH-1:0] s1_a,
  input  logic [DATA_WIDTH-1:0] s1_b,
  input  logic [DATA_WIDTH-1:0] s1_c,
  input  logic [DATA_WIDTH-1:0] s1_d,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_p,
  output logic                  m_match,
  output logic                  m_id,
  output logic                  busy
);

  localparam int CW     = $clog2(FIFO_DEPTH + 1);
  localparam int INFL_W = $clog2(DSP_LATENCY + 1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] p;
    logic                  match;
    logic                  id;
  } res_w_t;

  // Both operations wrap modulo 2^DATA_WIDTH; the lost carry bits are intended.
  function automatic logic signed [DATA_WIDTH-1:0] wrap_add(
    input logic signed [DATA_WIDTH-1:0] x,
    input logic signed [DATA_WIDTH-1:0] y
  );
    return x + y;
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] wrap_mul(
    input logic signed [DATA_WIDTH-1:0] x,
    input logic signed [DATA_WIDTH-1:0] y
  );
    return x * y;
  endfunction

  tag_t                   tag_p0, tag_p1, tag_p2;
  logic signed [DATA_WIDTH-1:0] sum_p0, b_p0, c_p0;
  logic signed [DATA_WIDTH-1:0] prod_p1, c_p1;
  logic signed [DATA_WIDTH-1:0] p_p2;
  logic                   match_p2;

  logic signed [DATA_WIDTH-1:0] op_a, op_b, op_c, op_d;
  logic                   last_q;
  logic                   rst_q;
  logic [INFL_W-1:0]      inflight;
  logic [CW-1:0]          fifo_cnt;
  logic                   fifo_empty;
  res_w_t                 push_item;
  res_w_t                 head;
  logic                   pop;
  logic                   credit_ok;
  logic                   arb_en;
  logic                   grant0, grant1;
  logic                   accept;

  assign inflight  = INFL_W'(tag_p0.valid) + INFL_W'(tag_p1.valid) + INFL_W'(tag_p2.valid);
  assign pop       = m_valid && m_ready;
  // A slot is reserved for every in-flight op; a same-cycle pop frees one.
  assign credit_ok = (32'(inflight) + 32'(fifo_cnt)) < (32'(FIFO_DEPTH) + 32'(pop));
  assign arb_en    = !rst && !rst_q && credit_ok;

  // last_q == 1 means requester 1 was granted last, so requester 0 is preferred.
  assign grant0   = s0_valid && (!s1_valid || last_q);
  assign grant1   = s1_valid && (!s0_valid || !last_q);
  assign s0_ready = arb_en && grant0;
  assign s1_ready = arb_en && grant1;
  assign accept   = s0_ready || s1_ready;

  assign op_a = s1_ready ? s1_a : s0_a;
  assign op_b = s1_ready ? s1_b : s0_b;
  assign op_c = s1_ready ? s1_c : s0_c;
  assign op_d = s1_ready ? s1_d : s0_d;

  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst) begin
      last_q <= 1'b1;
      tag_p0 <= '0;
      tag_p1 <= '0;
      tag_p2 <= '0;
      c_p0   <= '0;
      c_p1   <= '0;
    end else begin
      if (accept)
        last_q <= s1_ready;
      tag_p0 <= '{valid: accept, id: s1_ready};
      tag_p1 <= tag_p0;
      tag_p2 <= tag_p1;
      c_p0   <= op_c;
      c_p1   <= c_p0;
    end
  end

  always_ff @(posedge clk) begin
    // stage p0: operand sum
    sum_p0   <= wrap_add(op_a, op_d);
    b_p0     <= op_b;
    // stage p1: product
    prod_p1  <= wrap_mul(sum_p0, b_p0);
    // stage p2: result and compare against delayed c
    p_p2     <= prod_p1;
    match_p2 <= (prod_p1 == c_p1);
  end

  assign push_item = '{p: p_p2, match: match_p2, id: tag_p2.id};

  dsp_res_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .item_t (res_w_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tag_p2.valid),
    .din   (push_item),
    .pop   (pop),
    .dout  (head),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  assign m_valid = !rst && !fifo_empty;
  assign m_p     = m_valid ? head.p : '0;
  assign m_match = m_valid ? head.match : 1'b0;
  assign m_id    = m_valid ? head.id : 1'b0;
  assign busy    = !rst && ((inflight != '0) || !fifo_empty);

endmodule

// File: doc/dsp_sched.md
DSP_SCHED -- requirements
Module: dsp_sched

Interface
REQ-001 Parameter DATA_WIDTH, default 16, SHALL set the operand and result width in bits.
REQ-002 Parameter FIFO_DEPTH, default 4, minimum 1, SHALL set the number of result buffer entries.
REQ-003 clk  input  1  SHALL be the single clock; all state is updated on its rising edge.
REQ-004 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 s0_valid, s1_valid  input  1 each  SHALL flag a valid request from requester 0 and requester 1.
REQ-006 s0_ready, s1_ready  output  1 each  SHALL flag that the request is accepted this cycle.
REQ-007 sN_a, sN_b, sN_c, sN_d  input  DATA_WIDTH each  SHALL carry the operands of requester N.
REQ-008 m_valid  output  1, and m_ready  input  1, SHALL form the result handshake.
REQ-009 m_p  output  DATA_WIDTH  SHALL carry the computed result.
REQ-010 m_match  output  1  SHALL be 1 when the result equals operand c.
REQ-011 m_id  output  1  SHALL identify the requester that issued the result.
REQ-012 busy  output  1  SHALL be 1 while any operation is in flight or the result buffer is not empty.

Function
REQ-013 Result SHALL be p = ((a+d) mod 2^W * b) mod 2^W, with W = DATA_WIDTH; match SHALL be (p == c).
- Both truncations are deliberate; no saturation.
REQ-014 The datapath SHALL be a 3-stage, non-stallable pipeline:
- a+d is registered on the cycle after issue; the product is registered one cycle later; p and the compare result are registered one cycle after that.
- Operand c SHALL be delayed 2 cycles so it reaches the compare stage aligned with the product.
REQ-015 A request is accepted in a cycle where sN_valid && sN_ready; at most one request SHALL be accepted per cycle.
REQ-016 sN_ready SHALL depend only on sN_valid, the arbiter state and credit, so it is combinational from valid; a requester SHALL never be readied without sN_valid.
REQ-017 Arbitration SHALL be round-robin with a 1-bit last-grant pointer.
- If both requesters are valid, grant the one not granted last.
- If only one is valid, grant it.
- The pointer SHALL update only on an accepted request.
REQ-018 A 3-deep valid/id tag shift register SHALL travel alongside the pipeline; only tagged stage-3 outputs SHALL be pushed into the result FIFO.
REQ-019 Credit rule: issue SHALL be allowed only when inflight + fifo_count - pop < FIFO_DEPTH.
- inflight = number of set tag-valid bits.
- pop = m_valid && m_ready in the same cycle.
REQ-020 The credit rule SHALL guarantee the FIFO never overflows; a push into a full FIFO is an assertion failure.
REQ-021 The result FIFO SHALL be non-fall-through, first-in first-out, with push and pop allowed in the same cycle.
- m_valid = FIFO not empty.
- m_p, m_match, m_id SHALL come from the head entry and be stable while m_valid && !m_ready.
REQ-022 Latency: a request accepted in cycle T SHALL present m_valid no earlier than cycle T+4, and exactly at T+4 when the FIFO is empty.
REQ-023 Throughput: with m_ready held at 1 and FIFO_DEPTH >= 4, one accept and one result SHALL occur per cycle in steady state.
REQ-024 Simultaneous push and pop on an empty FIFO SHALL be impossible, because pop requires not empty.
REQ-025 Simultaneous push and pop on a non-empty FIFO SHALL leave the occupancy unchanged.

Reset
REQ-026 On rst, the block SHALL clear all tag-valid bits, the FIFO pointers and count, and the c delay line, and SHALL set the last-grant pointer to 1 so that requester 0 wins first.
REQ-027 During the reset cycle and the cycle after it, m_valid, s0_ready, s1_ready and busy SHALL be 0; m_p, m_match and m_id SHALL be 0.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight and buffered results; none SHALL appear after reset is released.

Structure
REQ-029 Package dsp_sched_pkg SHALL hold:
- DSP_LATENCY = 3;
- the result struct typedef {p, match, id};
- the tag struct typedef {valid, id}.
REQ-030 The result FIFO SHALL be a sub-module, dsp_res_fifo, parameterised by depth and the result struct; the arbiter, credit logic and pipeline stay in dsp_sched.

Verification
REQ-031 s0 only: a=3, d=2, b=4, c=20, accepted at T -> m_valid at T+4 with p=20, match=1, id=0.
REQ-032 s1 only: a=0xFFFF, d=1, b=5, c=1 -> p=0, match=0, id=1.
REQ-033 Both requesters valid every cycle and m_ready=1 -> grants 0,1,0,1,...; output ids alternate 0,1,...; one result per cycle from T+4 onward.
REQ-034 m_ready=0 with both requesters valid -> exactly 4 accepts, then both ready=0 and busy=1; m_ready then set to 1 -> 4 results in accept order, after which accepts resume.
REQ-035 Two accepts at T and T+1, rst asserted at T+2 for 1 cycle -> m_valid stays 0 afterwards, busy=0, and the next simultaneous request grants s0 first.
